// File: rtl/spi_flash_burst_reader.sv
// SPI NOR burst reader: 0x0B single or 0x3B dual fast read, 1..2^LEN_W bytes.
// Self-divided SCK (mode 0), stalled while a completed byte cannot be handed off.
module spi_flash_burst_reader #(
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 8,
    parameter int CLK_DIV     = 2,
    parameter int DUMMY_CYC   = 8,
    parameter int CS_HIGH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_dual,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              io0_o,
    output logic              io0_oe,
    input  logic              io0_i,
    input  logic              io1_i
);

    localparam int TX_W    = 8 + ADDR_W;
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int CNT_M0  = (ADDR_W > DUMMY_CYC) ? ADDR_W : DUMMY_CYC;
    localparam int CNT_MAX = (CNT_M0 > 8) ? CNT_M0 : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = $clog2(CS_HIGH_CYC + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              io0_q, io0_d;
    logic              oe_q, oe_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [LEN_W:0]    byte_q, byte_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              dual_q, dual_d;
    logic              done_q, done_d;
    logic [7:0]        hold_q, hold_d;
    logic              ov_q, ov_d;
    logic              last_q, last_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rdy_q, rdy_d;

    logic             active, run, tick, rise, fall, hs;
    logic             byte_done, is_last;
    logic [7:0]       cmd, rx_nxt;
    logic [CNT_W-1:0] bit_last;

    assign active    = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
    // A pending byte freezes SCK only once it has returned low
    assign run       = active && !(pend_q && !sclk_q);
    assign tick      = run && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise      = tick && !sclk_q;
    assign fall      = tick && sclk_q;
    assign hs        = rdy_q && req_valid;
    assign cmd       = req_dual ? 8'h3B : 8'h0B;
    assign rx_nxt    = dual_q ? {rx_q[5:0], io1_i, io0_i} : {rx_q[6:0], io1_i};
    assign bit_last  = dual_q ? CNT_W'(3) : CNT_W'(7);
    assign is_last   = (byte_q == {1'b0, len_q});
    assign byte_done = rise && (state_q == S_DATA) && (cnt_q == bit_last);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        io0_d       = io0_q;
        oe_d        = oe_q;
        tx_d        = tx_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        byte_d      = byte_q;
        len_d       = len_q;
        dual_d      = dual_q;
        done_d      = done_q;
        hold_d      = hold_q;
        ov_d        = ov_q;
        last_d      = last_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        wait_d      = wait_q;

        if (run) div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) sclk_d = !sclk_q;
        if (rise && state_q != S_DATA) cnt_d = cnt_q + CNT_W'(1);
        if (fall && (state_q == S_CMD || state_q == S_ADDR)) begin
            io0_d = tx_q[TX_W-1];
            tx_d  = tx_q << 1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_CMD;
                    cs_n_d  = 1'b0;
                    oe_d    = 1'b1;
                    io0_d   = cmd[7];
                    tx_d    = {cmd[6:0], req_addr, 1'b0};
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    cnt_d   = '0;
                    rx_d    = '0;
                    byte_d  = '0;
                    len_d   = req_len;
                    dual_d  = req_dual;
                    done_d  = 1'b0;
                end
            end
            S_CMD: begin
                if (fall && cnt_q == CNT_W'(8)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (fall && cnt_q == CNT_W'(ADDR_W)) begin
                    state_d = S_DUMMY;
                    cnt_d   = '0;
                    io0_d   = 1'b1;
                    oe_d    = !dual_q;
                end
            end
            S_DUMMY: begin
                if (fall && cnt_q == CNT_W'(DUMMY_CYC)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                end
            end
            S_DATA: begin
                if (rise) begin
                    rx_d = rx_nxt;
                    if (cnt_q == bit_last) begin
                        cnt_d  = '0;
                        byte_d = byte_q + 1'b1;
                        if (is_last) done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (fall && done_q) begin
                    state_d = S_CS_WAIT;
                    wait_d  = '0;
                end
            end
            S_CS_WAIT: begin
                cs_n_d = 1'b1;
                if (wait_q != WAIT_W'(CS_HIGH_CYC)) wait_d = wait_q + WAIT_W'(1);
                else if (!pend_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Holding register fed directly, or later from the parked shift register
        if (byte_done) begin
            if (!ov_q || out_ready) begin
                hold_d = rx_nxt;
                ov_d   = 1'b1;
                last_d = is_last;
            end else begin
                pend_d      = 1'b1;
                pend_last_d = is_last;
            end
        end else if (ov_q && out_ready) begin
            if (pend_q) begin
                hold_d = rx_q;
                last_d = pend_last_q;
                pend_d = 1'b0;
            end else begin
                ov_d = 1'b0;
            end
        end

        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            io0_q       <= 1'b1;
            oe_q        <= 1'b0;
            tx_q        <= '0;
            cnt_q       <= '0;
            rx_q        <= '0;
            byte_q      <= '0;
            len_q       <= '0;
            dual_q      <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= '0;
            ov_q        <= 1'b0;
            last_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            wait_q      <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            io0_q       <= io0_d;
            oe_q        <= oe_d;
            tx_q        <= tx_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            byte_q      <= byte_d;
            len_q       <= len_d;
            dual_q      <= dual_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            ov_q        <= ov_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            wait_q      <= wait_d;
            rdy_q       <= rdy_d;
        end
    end

    assign req_ready = rdy_q;
    assign out_valid = ov_q;
    assign out_data  = hold_q;
    assign out_last  = last_q;
    assign busy      = (state_q != S_IDLE) || ov_q;
    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign io0_o     = io0_q;
    assign io0_oe    = oe_q;

endmodule
